// File: rtl/uart_tx.sv
// UART transmit serializer: pops one byte from the TX fifo and sends
// start, DATA_BITS data bits (LSB first), optional parity and 1/2 stop bits.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_e;

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   div_q, cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [BW-1:0]          bit_q;
  logic                   par_en_q, par_bit_q, stop2_q, stop_2nd_q;
  logic                   tx_q, rd_q, busy_q, done_q;
  logic                   slot_end_d;

  assign slot_end_d = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_2nd_q <= 1'b0;
      tx_q       <= 1'b1;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      // Slot counter counts down; each slot-ending branch below reloads it.
      if (state_q inside {START, DATA, PARITY, STOP} && !slot_end_d)
        cnt_q <= cnt_q - 1'b1;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_enable && !fifo_empty) begin
            state_q <= FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          // fifo_data is valid now, one cycle after the pop strobe.
          shift_q   <= fifo_data;
          div_q     <= baud_div;
          cnt_q     <= baud_div;
          par_en_q  <= parity_en;
          par_bit_q <= (^fifo_data) ^ parity_odd;
          stop2_q   <= stop2;
          tx_q      <= 1'b0;
          state_q   <= START;
        end
        START: if (slot_end_d) begin
          cnt_q   <= div_q;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (slot_end_d) begin
          cnt_q <= div_q;
          if (bit_q == LAST_BIT) begin
            stop_2nd_q <= 1'b0;
            if (par_en_q) begin
              tx_q    <= par_bit_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
          end
        end
        PARITY: if (slot_end_d) begin
          cnt_q   <= div_q;
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: if (slot_end_d) begin
          cnt_q <= div_q;
          if (stop2_q && !stop_2nd_q) begin
            stop_2nd_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a small fifo model feeds bytes, and each frame
// is checked bit-slot by bit-slot against hand-specified framing.
module tb_uart_tx;

  logic        clk, reset, tx_enable, parity_en, parity_odd, stop2;
  logic [15:0] baud_div;
  logic        fifo_empty, fifo_rd_en, tx, busy, tx_done;
  logic [7:0]  fifo_data;

  logic [7:0] mem [0:15];
  int wr_ptr, rd_ptr, pops, bad_rd;
  int checks, errors;

  uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops++;
      if (fifo_empty) bad_rd++;
      else begin
        fifo_data <= mem[rd_ptr[3:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  // Waits for the start bit, then checks every cycle of every slot.
  task automatic frame(input logic [7:0] d, input int bd, input bit pe,
                       input bit pb, input bit s2, input int gap);
    logic bits [0:11];
    int n, hi;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pe) begin bits[n] = pb; n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    hi = 0;
    while (tx === 1'b1 && hi < 200) begin @(negedge clk); hi++; end
    chk($sformatf("start_%0h", d), {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) return;
    if (gap >= 0) chk("idle_gap", hi, gap);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int s = 0; s < n; s++)
      for (int c = 0; c <= bd; c++) begin
        chk($sformatf("tx_%0h_slot%0d_cyc%0d", d, s, c), {31'd0, tx}, {31'd0, bits[s]});
        @(negedge clk);
      end
    chk("tx_done_pulse", {31'd0, tx_done}, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("tx_idle_high", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    int p0;
    clk = 0; reset = 1; tx_enable = 1; baud_div = 16'd3;
    parity_en = 0; parity_odd = 0; stop2 = 0;
    wr_ptr = 0; rd_ptr = 0; pops = 0; bad_rd = 0; checks = 0; errors = 0;

    // 1: reset held with a non-empty fifo
    push(8'hA5);
    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
    end
    chk("rst_no_pop", pops, 0);
    reset = 0;

    // 2: 0xA5, div 3, no parity, 1 stop
    frame(8'hA5, 3, 0, 0, 0, -1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, tx_done}, 32'd0);
    chk("t2_pops", pops, 1);

    // 3: parity variants
    parity_en = 1; parity_odd = 0; baud_div = 16'd1;
    push(8'h07); frame(8'h07, 1, 1, 1, 0, -1);
    parity_odd = 1;
    push(8'h07); frame(8'h07, 1, 1, 0, 0, -1);
    parity_odd = 0;
    push(8'h00); frame(8'h00, 1, 1, 0, 0, -1);
    chk("t3_pops", pops, 4);

    // 4: back-to-back at 1 cycle/bit
    parity_en = 0; baud_div = 16'd0;
    push(8'hFF); push(8'h00);
    frame(8'hFF, 0, 0, 0, 0, -1);
    frame(8'h00, 0, 0, 0, 0, 3);
    repeat (10) @(negedge clk);
    chk("t4_pops", pops, 6);
    chk("t4_busy", {31'd0, busy}, 32'd0);

    // 5: two stop bits, config change and tx_enable drop mid-frame
    stop2 = 1; baud_div = 16'd1;
    push(8'h3C); push(8'h99);
    fork
      frame(8'h3C, 1, 0, 0, 1, -1);
      begin
        repeat (12) @(negedge clk);
        tx_enable = 0; baud_div = 16'd5; stop2 = 0;
      end
    join
    repeat (10) @(negedge clk);
    chk("t5_pops", pops, 7);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_tx", {31'd0, tx}, 32'd1);

    // 6: reset during DATA, then the next byte goes out cleanly
    baud_div = 16'd3; push(8'h5A); tx_enable = 1;
    p0 = 0;
    while (tx === 1'b1 && p0 < 50) begin @(negedge clk); p0++; end
    chk("t6_start", {31'd0, tx}, 32'd0);
    repeat (8) @(negedge clk);
    reset = 1;
    #1;
    chk("t6_rst_tx", {31'd0, tx}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 0;
    frame(8'h5A, 3, 0, 0, 0, -1);
    chk("t6_pops", pops, 9);
    chk("no_pop_when_empty", bad_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
